rf_scoreboard: RTL and testbench

- Parametrised successor to the single-cycle CPU register file, for the pipelined CPU.
- NR combinational read ports and two write ports (WB0 = ALU, WB1 = load/late unit).
- Write-to-read bypass plus a per-register busy scoreboard, so decode can detect RAW/WAW hazards and stall.
- Sits between decode/issue and the writeback stages.

---
 rtl/rf_pkg.sv | 23 ++
 rtl/rf_sb_core.sv | 72 +++++++
 rtl/rf_scoreboard.sv | 82 ++++++++
 tb/tb_rf_scoreboard.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the pipelined register file / scoreboard.
package rf_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned AW_DEF = 5;
  localparam int unsigned NR_MAX = 4;
  localparam int unsigned NWP    = 2;

  // Where a read port takes its data from this cycle
  typedef enum logic [1:0] {
    SRC_RF  = 2'd0,
    SRC_WP0 = 2'd1,
    SRC_WP1 = 2'd2
  } rd_src_e;

  // Bypass source selection from per-write-port hit flags; port 1 wins
  function automatic rd_src_e byp_sel(input logic [NWP-1:0] hit);
    if (hit[1])      return SRC_WP1;
    else if (hit[0]) return SRC_WP0;
    else             return SRC_RF;
  endfunction

endpackage

// File: rtl/rf_sb_core.sv
// Busy scoreboard: per-register pending-write bits, issue acceptance and
// a registered count of busy registers.
module rf_sb_core
  import rf_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NWP-1:0]      wr_en,
  input  logic [NWP*AW-1:0]   wr_addr,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic [2**AW-1:0]    busy,
  output logic                iss_ok,
  output logic [AW-1:0]       pend_cnt
);

  logic [AW-1:0]     wa0, wa1;
  logic              wv0, wv1;
  logic              iss_hit_wr;
  logic              iss_set;
  logic              inc, dec0, dec1;
  logic [2**AW-1:0]  clr_mask, set_mask, busy_nxt;
  logic [AW-1:0]     cnt_nxt;

  assign wa0 = wr_addr[0  +: AW];
  assign wa1 = wr_addr[AW +: AW];
  assign wv0 = wr_en[0] && (wa0 != '0);
  assign wv1 = wr_en[1] && (wa1 != '0);

  assign iss_hit_wr = (wv0 && (wa0 == iss_addr)) || (wv1 && (wa1 == iss_addr));
  assign iss_ok     = !flush && ((iss_addr == '0) || !busy[iss_addr] || iss_hit_wr);
  assign iss_set    = iss_en && iss_ok && (iss_addr != '0);

  // Counter deltas mirror the busy transitions: a set on an already-busy
  // register (completing write + new issue) is a no-op, and a doubled write
  // to one busy address counts once.
  assign inc  = iss_set && !busy[iss_addr];
  assign dec0 = wv0 && busy[wa0] && !(iss_set && (wa0 == iss_addr));
  assign dec1 = wv1 && busy[wa1] && !(iss_set && (wa1 == iss_addr))
                    && !(wv0 && (wa0 == wa1));

  // Next busy vector and next count: clears from writes, set from issue wins
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wv0)     clr_mask[wa0]      = 1'b1;
    if (wv1)     clr_mask[wa1]      = 1'b1;
    if (iss_set) set_mask[iss_addr] = 1'b1;
    if (flush) begin
      busy_nxt = '0;
      cnt_nxt  = '0;
    end else begin
      busy_nxt = (busy & ~clr_mask) | set_mask;
      cnt_nxt  = pend_cnt + AW'(inc) - AW'(dec0) - AW'(dec1);
    end
  end

  // Scoreboard state registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Register file for the pipelined CPU: NR bypassed combinational read ports,
// two writeback ports and a busy scoreboard for RAW/WAW hazard stalls.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned NR = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NR*AW-1:0]    rd_addr,
  output logic [NR*DW-1:0]    rd_data,
  output logic [NR-1:0]       rd_ready,
  input  logic [NWP-1:0]      wr_en,
  input  logic [NWP*AW-1:0]   wr_addr,
  input  logic [NWP*DW-1:0]   wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_ok,
  input  logic                flush,
  output logic [AW-1:0]       pend_cnt
);

  logic [DW-1:0]    rf [2**AW];
  logic [2**AW-1:0] busy;
  logic [AW-1:0]    wa0, wa1;

  assign wa0 = wr_addr[0  +: AW];
  assign wa1 = wr_addr[AW +: AW];

  rf_sb_core #(
    .AW(AW)
  ) u_sb (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy     (busy),
    .iss_ok   (iss_ok),
    .pend_cnt (pend_cnt)
  );

  // Data array write; port 1 is applied last so it wins on a collision
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rf <= '{default: '0};
    end else begin
      if (wr_en[0] && (wa0 != '0)) rf[wa0] <= wr_data[0  +: DW];
      if (wr_en[1] && (wa1 != '0)) rf[wa1] <= wr_data[DW +: DW];
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [AW-1:0]  ra;
    logic [NWP-1:0] hit;
    rd_src_e        src;
    logic [DW-1:0]  dout;

    assign ra     = rd_addr[k*AW +: AW];
    assign hit[0] = wr_en[0] && (wa0 == ra) && (ra != '0);
    assign hit[1] = wr_en[1] && (wa1 == ra) && (ra != '0);
    assign src    = byp_sel(hit);

    // Read mux: same-cycle write data bypasses the array; r0 reads zero
    always_comb begin
      dout = '0;
      case (src)
        SRC_WP1: dout = wr_data[DW +: DW];
        SRC_WP0: dout = wr_data[0  +: DW];
        default: dout = (ra == '0) ? '0 : rf[ra];
      endcase
    end

    assign rd_data[k*DW +: DW] = dout;
    assign rd_ready[k]         = (ra == '0) || (|hit) || !busy[ra];
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed vector table, reset
// sequences and randomized traffic against a behavioural model.
module tb_rf_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_ready;
  logic [1:0]        wr_en;
  logic [2*AW-1:0]   wr_addr;
  logic [2*DW-1:0]   wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              iss_ok;
  logic              flush;
  logic [AW-1:0]     pend_cnt;

  // Stimulus variables
  logic [1:0]  we;
  logic [4:0]  wa0, wa1, ia, ra0, ra1;
  logic [31:0] wd0, wd1;
  logic        ie, fl;

  assign wr_en    = we;
  assign wr_addr  = {wa1, wa0};
  assign wr_data  = {wd1, wd0};
  assign iss_en   = ie;
  assign iss_addr = ia;
  assign flush    = fl;
  assign rd_addr  = {ra1, ra0};

  rf_scoreboard #(.DW(DW), .AW(AW), .NR(NR)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_ready (rd_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_ok   (iss_ok),
    .flush    (flush),
    .pend_cnt (pend_cnt)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_rf   [32];
  bit          m_busy [32];

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (we[1] && wa1 == a) return wd1;
    if (we[0] && wa0 == a) return wd0;
    return m_rf[a];
  endfunction

  function automatic logic m_written(input logic [4:0] a);
    return (a != 0) && ((we[0] && wa0 == a) || (we[1] && wa1 == a));
  endfunction

  function automatic logic m_rdy(input logic [4:0] a);
    return (a == 0) || m_written(a) || !m_busy[a];
  endfunction

  function automatic logic m_ok();
    return !fl && ((ia == 0) || !m_busy[ia] || m_written(ia));
  endfunction

  function automatic logic [4:0] m_pend();
    int n = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
    return 5'(n);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   = 32'd0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic m_clock();
    logic ok;
    ok = m_ok();
    if (we[0] && wa0 != 0) m_rf[wa0] = wd0;
    if (we[1] && wa1 != 0) m_rf[wa1] = wd1;
    if (fl) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (we[0] && wa0 != 0) m_busy[wa0] = 1'b0;
      if (we[1] && wa1 != 0) m_busy[wa1] = 1'b0;
      if (ie && ok && ia != 0) m_busy[ia] = 1'b1;
    end
  endtask

  // ---------------- cycle driver ----------------
  logic [31:0] c_rd0, c_rd1, p_rd0, p_rd1;
  logic [1:0]  c_rdy, p_rdy;
  logic        c_ok, p_ok;
  logic [4:0]  c_pend, p_pend;

  task automatic idle();
    we = 2'b00; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    ie = 1'b0;  ia = '0;  fl = 1'b0; ra0 = '0; ra1 = '0;
  endtask

  // Inputs are set just after a negedge; returns at the following negedge
  task automatic cycle();
    #2;
    c_rd0 = rd_data[31:0];
    c_rd1 = rd_data[63:32];
    c_rdy = rd_ready;
    c_ok  = iss_ok;
    p_rd0 = m_read(ra0);
    p_rd1 = m_read(ra1);
    p_rdy = {m_rdy(ra1), m_rdy(ra0)};
    p_ok  = m_ok();
    @(posedge CLK);
    m_clock();
    #1;
    c_pend = pend_cnt;
    p_pend = m_pend();
    @(negedge CLK);
  endtask

  // Asynchronous reset pulse between clock edges, checked while asserted
  task automatic do_reset(input string tag);
    idle();
    ra0 = 5'd3; ra1 = 5'd7;
    #1 RST_N = 1'b0;
    m_reset();
    #1;
    check({tag, " pend_cnt"}, 64'(pend_cnt), 64'd0);
    check({tag, " iss_ok"},   64'(iss_ok),   64'd1);
    check({tag, " rd_ready"}, 64'(rd_ready), 64'h3);
    check({tag, " rd_data"},  64'(rd_data),  64'd0);
    #1 RST_N = 1'b1;
    @(negedge CLK);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  erdy;
    logic        eok;
    logic [4:0]  epend;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 5'($urandom);
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    //             we     wa0  wd0          wa1  wd1          ie  ia  fl  ra0 ra1  e0           e1           rdy    ok  pend
    tbl[0]  = '{2'b00, 5'd0, 32'h0,      5'd0, 32'h0,      1'b0, 5'd0, 1'b0, 5'd3, 5'd7, 32'h0,      32'h0,      2'b11, 1'b1, 5'd0};
    tbl[1]  = '{2'b00, 5'd0, 32'h0,      5'd0, 32'h0,      1'b1, 5'd5, 1'b0, 5'd5, 5'd0, 32'h0,      32'h0,      2'b11, 1'b1, 5'd1};
    tbl[2]  = '{2'b00, 5'd0, 32'h0,      5'd0, 32'h0,      1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 32'h0,      32'h0,      2'b10, 1'b1, 5'd1};
    tbl[3]  = '{2'b01, 5'd5, 32'h1234,   5'd0, 32'h0,      1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 32'h1234,   32'h1234,   2'b11, 1'b1, 5'd0};
    tbl[4]  = '{2'b00, 5'd0, 32'h0,      5'd0, 32'h0,      1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 32'h1234,   32'h0,      2'b11, 1'b1, 5'd0};
    tbl[5]  = '{2'b00, 5'd0, 32'h0,      5'd0, 32'h0,      1'b1, 5'd9, 1'b0, 5'd9, 5'd0, 32'h0,      32'h0,      2'b11, 1'b1, 5'd1};
    tbl[6]  = '{2'b11, 5'd9, 32'hAAAA,   5'd9, 32'h5555,   1'b0, 5'd0, 1'b0, 5'd9, 5'd9, 32'h5555,   32'h5555,   2'b11, 1'b1, 5'd0};
    tbl[7]  = '{2'b00, 5'd0, 32'h0,      5'd0, 32'h0,      1'b0, 5'd0, 1'b0, 5'd9, 5'd0, 32'h5555,   32'h0,      2'b11, 1'b1, 5'd0};
    tbl[8]  = '{2'b00, 5'd0, 32'h0,      5'd0, 32'h0,      1'b1, 5'd4, 1'b0, 5'd0, 5'd0, 32'h0,      32'h0,      2'b11, 1'b1, 5'd1};
    tbl[9]  = '{2'b00, 5'd0, 32'h0,      5'd0, 32'h0,      1'b1, 5'd4, 1'b0, 5'd4, 5'd0, 32'h0,      32'h0,      2'b10, 1'b0, 5'd1};
    tbl[10] = '{2'b10, 5'd0, 32'h0,      5'd4, 32'hBEEF,   1'b1, 5'd4, 1'b0, 5'd4, 5'd0, 32'hBEEF,   32'h0,      2'b11, 1'b1, 5'd1};
    tbl[11] = '{2'b00, 5'd0, 32'h0,      5'd0, 32'h0,      1'b0, 5'd0, 1'b0, 5'd4, 5'd0, 32'hBEEF,   32'h0,      2'b10, 1'b1, 5'd1};
    tbl[12] = '{2'b01, 5'd0, 32'hFFFF,   5'd0, 32'h0,      1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0,      32'h0,      2'b11, 1'b1, 5'd1};
    tbl[13] = '{2'b00, 5'd0, 32'h0,      5'd0, 32'h0,      1'b1, 5'd0, 1'b0, 5'd0, 5'd4, 32'h0,      32'hBEEF,   2'b01, 1'b1, 5'd1};
    tbl[14] = '{2'b00, 5'd0, 32'h0,      5'd0, 32'h0,      1'b1, 5'd2, 1'b0, 5'd0, 5'd0, 32'h0,      32'h0,      2'b11, 1'b1, 5'd2};
    tbl[15] = '{2'b00, 5'd0, 32'h0,      5'd0, 32'h0,      1'b1, 5'd3, 1'b0, 5'd0, 5'd0, 32'h0,      32'h0,      2'b11, 1'b1, 5'd3};
    tbl[16] = '{2'b01, 5'd4, 32'h44,     5'd0, 32'h0,      1'b1, 5'd6, 1'b0, 5'd4, 5'd6, 32'h44,     32'h0,      2'b11, 1'b1, 5'd3};
    tbl[17] = '{2'b01, 5'd3, 32'h7,      5'd0, 32'h0,      1'b1, 5'd8, 1'b1, 5'd3, 5'd8, 32'h7,      32'h0,      2'b11, 1'b0, 5'd0};
    tbl[18] = '{2'b00, 5'd0, 32'h0,      5'd0, 32'h0,      1'b0, 5'd8, 1'b0, 5'd3, 5'd8, 32'h7,      32'h0,      2'b11, 1'b1, 5'd0};
    tbl[19] = '{2'b10, 5'd0, 32'h0,      5'd2, 32'h22,     1'b0, 5'd0, 1'b0, 5'd2, 5'd0, 32'h22,     32'h0,      2'b11, 1'b1, 5'd0};

    idle();
    RST_N = 1'b1;
    m_reset();
    @(negedge CLK);
    do_reset("init_reset");

    // Directed table
    for (int i = 0; i < NV; i++) begin
      we  = tbl[i].we;  wa0 = tbl[i].wa0; wd0 = tbl[i].wd0;
      wa1 = tbl[i].wa1; wd1 = tbl[i].wd1;
      ie  = tbl[i].ie;  ia  = tbl[i].ia;  fl  = tbl[i].fl;
      ra0 = tbl[i].ra0; ra1 = tbl[i].ra1;
      cycle();
      check($sformatf("vec%0d rd0", i),      64'(c_rd0),  64'(tbl[i].e0));
      check($sformatf("vec%0d rd1", i),      64'(c_rd1),  64'(tbl[i].e1));
      check($sformatf("vec%0d rd_ready", i), 64'(c_rdy),  64'(tbl[i].erdy));
      check($sformatf("vec%0d iss_ok", i),   64'(c_ok),   64'(tbl[i].eok));
      check($sformatf("vec%0d pend_cnt", i), 64'(c_pend), 64'(tbl[i].epend));
    end

    // Reset in the middle of operation: r7 busy, array holds data
    idle(); ie = 1'b1; ia = 5'd7;
    cycle();
    check("mid issue r7 pend_cnt", 64'(c_pend), 64'd1);
    do_reset("mid_reset");
    idle(); ra0 = 5'd3; ra1 = 5'd2;
    cycle();
    check("post reset rd r3", 64'(c_rd0), 64'd0);
    check("post reset rd r2", 64'(c_rd1), 64'd0);
    idle(); ie = 1'b1; ia = 5'd7; ra0 = 5'd7;
    cycle();
    check("post reset issue iss_ok", 64'(c_ok),   64'd1);
    check("post reset issue pend",   64'(c_pend), 64'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      we[0] = ($urandom_range(0, 9) < 4);
      we[1] = ($urandom_range(0, 9) < 4);
      wa0 = rand_addr(); wa1 = rand_addr();
      wd0 = $urandom;    wd1 = $urandom;
      ie  = 1'($urandom_range(0, 1));
      ia  = rand_addr();
      fl  = ($urandom_range(0, 29) == 0);
      ra0 = rand_addr(); ra1 = rand_addr();
      cycle();
      check($sformatf("rnd%0d rd0", n),      64'(c_rd0),  64'(p_rd0));
      check($sformatf("rnd%0d rd1", n),      64'(c_rd1),  64'(p_rd1));
      check($sformatf("rnd%0d rd_ready", n), 64'(c_rdy),  64'(p_rdy));
      check($sformatf("rnd%0d iss_ok", n),   64'(c_ok),   64'(p_ok));
      check($sformatf("rnd%0d pend_cnt", n), 64'(c_pend), 64'(p_pend));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
